// File: rtl/uart_axi_buffer_if.sv
// uart_axi_buffer_if: AXI4-Lite bus between the memory stage and the UART buffer.
interface uart_axi_buffer_if;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  araddr, arprot, arvalid, rready,
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arprot, arvalid, rready,
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/uart_axi_buffer.sv
// uart_axi_buffer: AXI4-Lite slave holding the UART RX and TX byte FIFOs.
// Reads/writes stall their response until RX data or TX space is available.
// Optional macro UART_AXI_BUFFER_LOOPBACK_EN: TX FIFO feeds RX FIFO internally
// (tx_valid held low, rx_data/rx_valid/tx_ready ignored) for CPU-only self-test.
module uart_axi_buffer #(
  parameter int unsigned RX_DEPTH_LOG2 = 4,
  parameter int unsigned TX_DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rstn,
  uart_axi_buffer_if.slave axi,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);
  localparam int unsigned RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int unsigned TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int unsigned RXP      = RX_DEPTH_LOG2 + 1;
  localparam int unsigned TXP      = TX_DEPTH_LOG2 + 1;

  localparam logic [3:0] OFF_RX      = 4'h0;
  localparam logic [3:0] OFF_TX      = 4'h4;
  localparam logic [3:0] OFF_ST      = 4'h8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_PUSH, W_RESP} w_state_e;

  r_state_e r_state, r_next;
  w_state_e w_state, w_next;

  logic [RXP-1:0] rx_wp, rx_rp;
  logic [7:0]     rx_mem [RX_DEPTH];
  logic           rx_empty, rx_full, rx_push, rx_pop, rx_ovf, ovf_set, ovf_clr;
  logic [7:0]     rx_in;
  logic           rx_in_valid;

  logic [TXP-1:0] tx_wp, tx_rp, tx_wp_n, tx_rp_n;
  logic [7:0]     tx_mem [TX_DEPTH];
  logic           tx_empty, tx_full, tx_push, tx_pop, tx_valid_q;
  logic [7:0]     tx_data_q;

  logic [3:0]  r_addr;
  logic [31:0] rd_word;
  logic [1:0]  rd_resp;

  logic        aw_have, w_have, aw_fire, w_fire, aw_got, w_got, aw_have_n, w_have_n;
  logic [3:0]  w_addr;
  logic [7:0]  w_byte;
  logic        w_strb0;
  logic [1:0]  wr_resp;

  logic unused_bits;
  assign unused_bits = ^{axi.araddr[31:4], axi.awaddr[31:4], axi.arprot, axi.awprot,
                         axi.wdata[31:8], axi.wstrb[3:1], tx_empty};

`ifdef UART_AXI_BUFFER_LOOPBACK_EN
  logic unused_lb;
  assign unused_lb   = ^{rx_data, rx_valid, tx_ready};
  assign tx_pop      = tx_valid_q && !rx_full;
  assign rx_in       = tx_data_q;
  assign rx_in_valid = tx_pop;
  assign tx_valid    = 1'b0;
`else
  assign tx_pop      = tx_valid_q && tx_ready;
  assign rx_in       = rx_data;
  assign rx_in_valid = rx_valid;
  assign tx_valid    = tx_valid_q;
`endif
  assign tx_data = tx_data_q;

  // RX FIFO flags and strobes; a full FIFO still accepts a byte when popped the same cycle
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[RXP-1] != rx_rp[RXP-1]) && (rx_wp[RXP-2:0] == rx_rp[RXP-2:0]);
  assign rx_pop   = (r_state == R_RESP) && axi.rready && (r_addr == OFF_RX);
  assign rx_push  = rx_in_valid && (!rx_full || rx_pop);
  assign ovf_set  = rx_in_valid && rx_full && !rx_pop;
  assign ovf_clr  = (r_state == R_RESP) && axi.rready && (r_addr == OFF_ST);

  // RX pointers and sticky overflow; a new overflow wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_ovf <= 1'b0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + RXP'(1);
      if (rx_pop)  rx_rp <= rx_rp + RXP'(1);
      if (ovf_set)      rx_ovf <= 1'b1;
      else if (ovf_clr) rx_ovf <= 1'b0;
    end
  end

  // RX storage
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[RXP-2:0]] <= rx_in;
  end

  // TX FIFO flags and next pointers
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[TXP-1] != tx_rp[TXP-1]) && (tx_wp[TXP-2:0] == tx_rp[TXP-2:0]);
  assign tx_push  = (w_state == W_PUSH) && (w_addr == OFF_TX) && !tx_full && w_strb0;
  assign tx_wp_n  = tx_wp + TXP'(tx_push);
  assign tx_rp_n  = tx_rp + TXP'(tx_pop);

  // TX pointers plus registered head (bypass when the pushed byte becomes the head)
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_wp      <= '0;
      tx_rp      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_wp      <= tx_wp_n;
      tx_rp      <= tx_rp_n;
      tx_valid_q <= (tx_wp_n != tx_rp_n);
      tx_data_q  <= (tx_push && (tx_wp[TXP-2:0] == tx_rp_n[TXP-2:0])) ? w_byte
                                                                       : tx_mem[tx_rp_n[TXP-2:0]];
    end
  end

  // TX storage
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[TXP-2:0]] <= w_byte;
  end

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  // Read FSM next state and read-data decode
  always_comb begin
    r_next  = r_state;
    rd_word = '0;
    rd_resp = RESP_OKAY;
    case (r_addr)
      OFF_RX:  rd_word = {24'h0, rx_mem[rx_rp[RXP-2:0]]};
      OFF_TX:  rd_word = '0;
      OFF_ST:  rd_word = {29'h0, rx_ovf, tx_full, !rx_empty};
      default: rd_resp = RESP_SLVERR;
    endcase
    case (r_state)
      R_IDLE:  if (axi.arvalid) r_next = R_WAIT;
      R_WAIT:  if (!((r_addr == OFF_RX) && rx_empty)) r_next = R_RESP;
      R_RESP:  if (axi.rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read channel registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      axi.arready <= 1'b1;
      axi.rvalid  <= 1'b0;
      axi.rdata   <= '0;
      axi.rresp   <= '0;
      r_addr      <= '0;
    end else begin
      axi.arready <= (r_next == R_IDLE);
      axi.rvalid  <= (r_next == R_RESP);
      if ((r_state == R_IDLE) && axi.arvalid) r_addr <= axi.araddr[3:0];
      if ((r_state == R_WAIT) && (r_next == R_RESP)) begin
        axi.rdata <= rd_word;
        axi.rresp <= rd_resp;
      end
    end
  end

  // Write channel capture bookkeeping
  assign aw_fire   = axi.awvalid && axi.awready;
  assign w_fire    = axi.wvalid && axi.wready;
  assign aw_got    = aw_have || aw_fire;
  assign w_got     = w_have || w_fire;
  assign aw_have_n = (w_state == W_IDLE) && (w_next == W_IDLE) && aw_got;
  assign w_have_n  = (w_state == W_IDLE) && (w_next == W_IDLE) && w_got;
  assign wr_resp   = ((w_addr == OFF_RX) || (w_addr == OFF_TX) || (w_addr == OFF_ST))
                     ? RESP_OKAY : RESP_SLVERR;

  // Write FSM state register
  always_ff @(posedge clk) begin
    if (!rstn) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  // Write FSM next state
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_got && w_got) w_next = W_PUSH;
      W_PUSH:  if (!((w_addr == OFF_TX) && tx_full)) w_next = W_RESP;
      W_RESP:  if (axi.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write channel registered outputs and captured payload
  always_ff @(posedge clk) begin
    if (!rstn) begin
      aw_have     <= 1'b0;
      w_have      <= 1'b0;
      axi.awready <= 1'b1;
      axi.wready  <= 1'b1;
      axi.bvalid  <= 1'b0;
      axi.bresp   <= '0;
      w_addr      <= '0;
      w_byte      <= '0;
      w_strb0     <= 1'b0;
    end else begin
      aw_have     <= aw_have_n;
      w_have      <= w_have_n;
      axi.awready <= (w_next == W_IDLE) && !aw_have_n;
      axi.wready  <= (w_next == W_IDLE) && !w_have_n;
      axi.bvalid  <= (w_next == W_RESP);
      if (aw_fire) w_addr <= axi.awaddr[3:0];
      if (w_fire) begin
        w_byte  <= axi.wdata[7:0];
        w_strb0 <= axi.wstrb[0];
      end
      if ((w_state == W_PUSH) && (w_next == W_RESP)) axi.bresp <= wr_resp;
    end
  end
endmodule

// File: tb/tb_uart_axi_buffer.sv
// tb_uart_axi_buffer: directed scoreboard bench for uart_axi_buffer.
module tb_uart_axi_buffer;
  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  int checks   = 0;
  int failures = 0;

  logic [33:0] exp_r[$];
  logic [1:0]  exp_b[$];
  logic [7:0]  exp_tx[$];

  localparam logic [31:0] A_RX = 32'h7F00_0000;
  localparam logic [31:0] A_TX = 32'h7F00_0004;
  localparam logic [31:0] A_ST = 32'h7F00_0008;
  localparam logic [31:0] A_UM = 32'h7F00_000C;

  uart_axi_buffer_if axi();

  uart_axi_buffer #(.RX_DEPTH_LOG2(4), .TX_DEPTH_LOG2(4)) dut (
    .clk(clk), .rstn(rstn), .axi(axi),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected responses whenever a handshake is presented
  initial begin
    logic [33:0] er;
    logic [1:0]  eb;
    logic [7:0]  et;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1) begin
        if (axi.rvalid && axi.rready) begin
          if (exp_r.size() == 0) begin
            checks++; failures++;
            $display("FAIL r_unexpected: got rdata 0x%0h with no read expected", axi.rdata);
          end else begin
            er = exp_r.pop_front();
            check("rdata", 64'(axi.rdata), 64'(er[31:0]));
            check("rresp", 64'(axi.rresp), 64'(er[33:32]));
          end
        end
        if (axi.bvalid && axi.bready) begin
          if (exp_b.size() == 0) begin
            checks++; failures++;
            $display("FAIL b_unexpected: got bresp 0x%0h with no write expected", axi.bresp);
          end else begin
            eb = exp_b.pop_front();
            check("bresp", 64'(axi.bresp), 64'(eb));
          end
        end
        if (tx_valid && tx_ready) begin
          if (exp_tx.size() == 0) begin
            checks++; failures++;
            $display("FAIL tx_unexpected: got tx_data 0x%0h with no byte expected", tx_data);
          end else begin
            et = exp_tx.pop_front();
            check("tx_data", 64'(tx_data), 64'(et));
          end
        end
      end
    end
  end

  task automatic ar_send(input logic [31:0] a);
    int n = 0;
    axi.araddr  = a;
    axi.arvalid = 1'b1;
    while (!axi.arready && n < 100) begin tick(); n++; end
    if (n >= 100) timeout_fail("ar_accept");
    tick();
    axi.arvalid = 1'b0;
  endtask

  task automatic r_wait(output int n);
    n = 0;
    while (!axi.rvalid && n < 200) begin tick(); n++; end
    if (n >= 200) timeout_fail("rvalid_wait");
    tick();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    int n;
    exp_r.push_back({resp, d});
    ar_send(a);
    r_wait(n);
  endtask

  task automatic wr_send(input logic [31:0] a, input logic [31:0] d, input int lag);
    int n = 0;
    axi.awaddr  = a;
    axi.awvalid = 1'b1;
    if (lag == 0) begin
      axi.wdata  = d;
      axi.wstrb  = 4'h1;
      axi.wvalid = 1'b1;
    end
    while (!(axi.awready && axi.wready) && n < 100) begin tick(); n++; end
    if (n >= 100) timeout_fail("aw_accept");
    tick();
    axi.awvalid = 1'b0;
    if (lag == 0) begin
      axi.wvalid = 1'b0;
    end else begin
      check("awready_drop", 64'(axi.awready), 64'd0);
      repeat (lag - 1) tick();
      axi.wdata  = d;
      axi.wstrb  = 4'h1;
      axi.wvalid = 1'b1;
      n = 0;
      while (!axi.wready && n < 100) begin tick(); n++; end
      if (n >= 100) timeout_fail("w_accept");
      tick();
      axi.wvalid = 1'b0;
    end
  endtask

  task automatic b_wait(output int n);
    n = 0;
    while (!axi.bvalid && n < 200) begin tick(); n++; end
    if (n >= 200) timeout_fail("bvalid_wait");
    tick();
  endtask

  task automatic rx_send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic flag;
    rstn = 1'b0;
    rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b1;
    tick(); tick();

    // Reset values
    check("rst_arready", 64'(axi.arready), 64'd1);
    check("rst_awready", 64'(axi.awready), 64'd1);
    check("rst_wready",  64'(axi.wready),  64'd1);
    check("rst_rvalid",  64'(axi.rvalid),  64'd0);
    check("rst_bvalid",  64'(axi.bvalid),  64'd0);
    check("rst_tx_valid", 64'(tx_valid),   64'd0);
    check("rst_rdata",   64'(axi.rdata),   64'd0);
    check("rst_rresp",   64'(axi.rresp),   64'd0);
    check("rst_bresp",   64'(axi.bresp),   64'd0);
    rstn = 1'b1;
    tick();

    // Two RX bytes read back in order, then status clear
    rx_send(8'h41);
    rx_send(8'h42);
    exp_r.push_back({2'b00, 32'h41});
    ar_send(A_RX);
    r_wait(n);
    check("ar_to_rvalid_latency", 64'(n), 64'd1);
    rd(A_RX, 32'h42, 2'b00);
    rd(A_ST, 32'h0, 2'b00);

    // Blocked RX read released by a late byte
    exp_r.push_back({2'b00, 32'h5A});
    ar_send(A_RX);
    flag = 1'b0;
    repeat (10) begin
      if (axi.rvalid) flag = 1'b1;
      tick();
    end
    check("no_early_rvalid", 64'(flag), 64'd0);
    rx_send(8'h5A);
    check("rvalid_inject_plus1", 64'(axi.rvalid), 64'd0);
    tick();
    check("rvalid_inject_plus2", 64'(axi.rvalid), 64'd1);
    tick();

    // RX overflow: 17 strobes, 17th dropped
    for (int i = 0; i < 17; i++) rx_send(8'(8'h60 + i));
    rd(A_ST, 32'h5, 2'b00);
    rd(A_ST, 32'h1, 2'b00);
    for (int i = 0; i < 16; i++) rd(A_RX, 32'(8'h60 + i), 2'b00);
    rd(A_ST, 32'h0, 2'b00);

    // TX fill with tx_ready low; 17th write stalls until space frees
    for (int i = 0; i < 16; i++) begin
      exp_b.push_back(2'b00);
      exp_tx.push_back(8'(8'h30 + i));
      wr_send(A_TX, 32'(8'h30 + i), 0);
      b_wait(n);
      if (i == 0) check("aw_to_bvalid_latency", 64'(n), 64'd1);
    end
    exp_b.push_back(2'b00);
    exp_tx.push_back(8'h40);
    wr_send(A_TX, 32'h40, 0);
    flag = 1'b0;
    repeat (6) begin
      if (axi.bvalid) flag = 1'b1;
      tick();
    end
    check("b_held_while_full", 64'(flag), 64'd0);
    rd(A_ST, 32'h2, 2'b00);
    check("tx_head_before_ready", 64'(tx_data), 64'h30);
    tx_ready = 1'b1;
    b_wait(n);
    n = 0;
    while (tx_valid && n < 100) begin tick(); n++; end
    if (n >= 100) timeout_fail("tx_drain");
    check("tx_drained", 64'(exp_tx.size()), 64'd0);

    // Unmapped offset with split AW/W, and discarded-but-OK accesses
    exp_b.push_back(2'b10);
    wr_send(A_UM, 32'hAB, 3);
    b_wait(n);
    check("no_tx_push_unmapped", 64'(tx_valid), 64'd0);
    rd(A_UM, 32'h0, 2'b10);
    rd(A_TX, 32'h0, 2'b00);
    exp_b.push_back(2'b00);
    wr_send(A_RX, 32'h99, 0);
    b_wait(n);
    rd(A_ST, 32'h0, 2'b00);

    // Reset during a blocked RX read, with a byte parked in TX
    tx_ready = 1'b0;
    exp_b.push_back(2'b00);
    wr_send(A_TX, 32'h77, 0);
    b_wait(n);
    check("tx_parked_valid", 64'(tx_valid), 64'd1);
    ar_send(A_RX);
    tick(); tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("post_rst_arready", 64'(axi.arready), 64'd1);
    check("post_rst_rvalid",  64'(axi.rvalid),  64'd0);
    check("post_rst_tx_valid", 64'(tx_valid),   64'd0);
    flag = 1'b0;
    repeat (5) begin
      if (axi.rvalid) flag = 1'b1;
      tick();
    end
    check("post_rst_no_rvalid", 64'(flag), 64'd0);
    rd(A_ST, 32'h0, 2'b00);
    tx_ready = 1'b1;

    repeat (5) tick();
    check("exp_r_empty",  64'(exp_r.size()),  64'd0);
    check("exp_b_empty",  64'(exp_b.size()),  64'd0);
    check("exp_tx_empty", 64'(exp_tx.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_axi_buffer.md
Name: uart_axi_buffer

Overview:
- AXI4-Lite slave holding the UART RX and TX byte FIFOs.
- The memory stage reaches it through its uart_axi_* bus for any address in 0x7Fxx_xxxx: lbu reads an RX byte, sb writes a TX byte.
- Sits between the memory stage and the serial UART core; decouples the core from line timing.
- Reads and writes block (stall the AXI response) until data or space is available.

Parameters:
- RX_DEPTH_LOG2, 4, log2 of RX FIFO depth (16 bytes).
- TX_DEPTH_LOG2, 4, log2 of TX FIFO depth (16 bytes).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rstn  in  1  reset; synchronous, active-low.
- axi_araddr  in  32  read address; only [3:0] decoded.
- axi_arvalid  in  1 / axi_arready  out  1  read-address handshake.
- axi_arprot  in  3  ignored.
- axi_rdata  out  32 / axi_rresp  out  2 / axi_rvalid  out  1 / axi_rready  in  1  read-data channel.
- axi_awaddr  in  32  write address; only [3:0] decoded.
- axi_awvalid  in  1 / axi_awready  out  1  write-address handshake.
- axi_awprot  in  3  ignored.
- axi_wdata  in  32 / axi_wstrb  in  4 / axi_wvalid  in  1 / axi_wready  out  1  write-data channel.
- axi_bresp  out  2 / axi_bvalid  out  1 / axi_bready  in  1  write-response channel.
- rx_data  in  8 / rx_valid  in  1  received byte from UART core; 1-cycle strobe, no backpressure.
- tx_data  out  8 / tx_valid  out  1 / tx_ready  in  1  byte to UART transmitter; transfer when valid&ready.

Behaviour:
- Register map (addr[3:0]):
  - 0x0 RX data (read pops one byte; zero-extended into rdata).
  - 0x4 TX data (write pushes wdata[7:0] when wstrb[0]=1).
  - 0x8 status: bit0 rx_nonempty, bit1 tx_full, bit2 rx_overflow (sticky; cleared by a status read).
  - All other offsets unmapped: read returns 0 with SLVERR (2'b10); write is discarded with SLVERR.
  - A read of 0x4 returns 0 with OKAY; a write to 0x0 or 0x8 is discarded with OKAY.
- Reset values (rstn low at posedge): FIFOs empty, overflow=0, arready=1, awready=1, wready=1, rvalid=0, bvalid=0, tx_valid=0, rdata=0, rresp=0, bresp=0. A reset mid-transaction abandons it; no response is issued.
- Read FSM:
  - R_IDLE: arready=1. On arvalid, latch addr[3:0], drop arready, go to R_WAIT.
  - R_WAIT: for 0x0 with RX empty, stay until nonempty. Otherwise load rdata/rresp and go to R_RESP.
  - R_RESP: rvalid=1 and rdata held stable. On rready, pop RX if addr=0x0, clear overflow if addr=0x8, go to R_IDLE (arready=1 next cycle).
  - Minimum latency: AR accepted at cycle N -> rvalid at N+2.
- Write FSM:
  - W_IDLE: awready=wready=1. AW and W are accepted independently in the same or different cycles; each ready drops once its channel is captured.
  - When both are captured, go to W_PUSH.
  - W_PUSH: for 0x4, wait while TX full, then push the byte. Go to W_RESP.
  - W_RESP: bvalid=1 until bready, then back to W_IDLE.
  - Minimum latency: AW+W accepted at cycle N -> bvalid at N+2.
- RX FIFO:
  - Push on rx_valid.
  - If full and no pop that cycle: byte dropped, rx_overflow set.
  - If full with a simultaneous pop: push accepted.
- TX FIFO:
  - tx_valid = !empty; tx_data = head (first-word-fall-through).
  - Pop on tx_valid&tx_ready.
  - A push and pop in the same cycle while full is not possible (W_PUSH waits on full); a same-cycle push and pop otherwise keeps the count unchanged.
- FIFO pointers are RX_DEPTH_LOG2+1 / TX_DEPTH_LOG2+1 bits wide and wrap naturally. full = MSBs differ and lower bits equal.
- Status reflects FIFO state as sampled in R_WAIT.

Optional Feature:
- Macro: UART_AXI_BUFFER_LOOPBACK_EN.
- Defined:
  - tx_valid is forced to 0 and tx_ready is ignored.
  - Each cycle the TX FIFO is nonempty and the RX FIFO is not full, one byte moves from TX head to RX tail.
  - rx_data/rx_valid are ignored.
  - Used for the CPU-only self-test.
- Undefined: normal operation as above.

Test Plan:
- rx_valid strobes 0x41 then 0x42; two reads of 0x0 -> rdata 0x00000041 then 0x00000042, rresp 0; status read after -> 0x0.
- Read 0x0 with RX empty; inject rx 0x5A 10 cycles later -> rvalid rises two cycles after the injection with rdata 0x5A; no earlier rvalid.
- 17 writes of 0x30..0x40 to 0x4 with tx_ready=0:
  - 16 writes complete with bresp 0.
  - The 17th write's bvalid is held off.
  - Raise tx_ready: tx_data sequence starts at 0x30; the 17th write completes; the FIFO drains to 0x40.
- 17 rx strobes with no reads -> status 0x5 (nonempty, overflow); a second status read -> 0x1; 16 reads of 0x0 return the first 16 bytes; the 17th byte is lost.
- AW at cycle N, W at cycle N+3, offset 0xC -> bvalid with bresp 2'b10, no tx push; read 0xC -> rdata 0, rresp 2'b10.
- rstn low for one cycle while a blocked 0x0 read is in R_WAIT -> rvalid stays 0, arready=1 the cycle after reset, FIFOs empty, status 0x0.
